// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and tap-index helpers for the 3x3 convolution window sequencer.
// Taps are numbered row-major inside the window: k = kr*3 + kc.
package conv_pkg;

    localparam int K    = 3;
    localparam int TAPS = K * K;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] tap_kr(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: return 2'd0;
            4'd3, 4'd4, 4'd5: return 2'd1;
            4'd6, 4'd7, 4'd8: return 2'd2;
            default:          return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tap_kc(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            4'd2, 4'd5, 4'd8: return 2'd2;
            default:          return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Combinational ROM address for tap k of the window whose top-left pixel is (row, col).
// Zero latency; no flow control.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 6,
    parameter int M     = 6
) (
    input  logic [7:0]   row,
    input  logic [7:0]   col,
    input  logic [3:0]   k,
    output logic [M-1:0] adr
);

    // Wide enough that the intermediate product never wraps before the final truncation.
    localparam int AW = M + 10;

    assign adr = M'((AW'(row) + AW'(tap_kr(k))) * AW'(IMG_W) + AW'(col) + AW'(tap_kc(k)));

endmodule

// File: rtl/conv_window_ctrl.sv
// Walks every 3x3 window of a row-major image in ROM, one tap per cycle, then offers it on valid/ready.
// 9 fetch cycles + 1 present cycle per window; while win_ready is low the window and address are frozen.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 6,
    parameter int IMG_W = 6,
    parameter int IMG_H = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [M-1:0]      rom_adr,
    input  logic [N-1:0]      rom_data,
    output logic [9*N-1:0]    win,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic              busy,
    output logic              done
);

    state_t       state, state_nxt;
    logic [3:0]   k;
    logic [7:0]   row, col;
    logic [M-1:0] adr;
    logic         last_col, last_row;

    assign last_col = (col == 8'(IMG_W - K));
    assign last_row = (row == 8'(IMG_H - K));

    conv_addr_gen #(.IMG_W(IMG_W), .M(M)) u_addr_gen (
        .row (row),
        .col (col),
        .k   (k),
        .adr (adr)
    );

    assign rom_adr = (state == IDLE) ? '0 : adr;
    assign out_row = row;
    assign out_col = col;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        win_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                if (k == 4'(TAPS - 1)) state_nxt = VALID;
            end
            VALID: begin
                win_valid = 1'b1;
                if (win_ready) state_nxt = (last_row && last_col) ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k   <= '0;
            row <= '0;
            col <= '0;
            win <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k   <= '0;
                        row <= '0;
                        col <= '0;
                    end
                end
                FETCH: begin
                    win[k*N +: N] <= rom_data;
                    k             <= (k == 4'(TAPS - 1)) ? 4'd0 : k + 4'd1;
                end
                VALID: begin
                    // Position moves only on handshake so out_row/out_col track the presented window.
                    if (win_ready) begin
                        if (last_col && last_row) begin
                            row <= '0;
                            col <= '0;
                        end else if (last_col) begin
                            col <= '0;
                            row <= row + 8'd1;
                        end else begin
                            col <= col + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
